// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between vga_timing_gen and the pixel pipeline.
// The generator owns every signal except the run enable.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10,
    parameter int RGB_W = 12
);
    logic             en;
    logic             pix_tick;
    logic             HS;
    logic             VS;
    logic             vidSel;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
    logic [RGB_W-1:0] rgb;

    modport master (
        input  en,
        output pix_tick, HS, VS, vidSel, hcount, vcount, x, y,
               line_start, frame_start, rgb
    );

    modport slave (
        output en,
        input  pix_tick, HS, VS, vidSel, hcount, vcount, x, y,
               line_start, frame_start, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, H/V counters, registered decode.
// Define VGA_TEST_PATTERN_EN to drive eight vertical colour bars on rgb; otherwise rgb is tied low.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int RGB_W    = 12
) (
    input logic              clk100,
    input logic              reset_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] d;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             tick;
    logic             moved;
    logic [CNT_W:0]   hx;
    logic [CNT_W:0]   vx;
    logic             hs_on;
    logic             vs_on;
    logic             active;
    logic [CNT_W-1:0] x_n;
    logic [CNT_W-1:0] y_n;

    assign tick         = vga.en && (d == DIV_LAST);
    assign vga.pix_tick = tick;

    // Divider and raster counters all freeze while en is low.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            d <= '0;
            h <= '0;
            v <= '0;
        end else if (vga.en) begin
            d <= (d == DIV_LAST) ? '0 : d + 1'b1;
            if (tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    // One extra bit keeps range limits equal to 2**CNT_W representable.
    always_comb begin
        hx     = {1'b0, h};
        vx     = {1'b0, v};
        hs_on  = hx < (CNT_W+1)'(H_SYNC);
        vs_on  = vx < (CNT_W+1)'(V_SYNC);
        active = (hx >= (CNT_W+1)'(H_ACT0)) && (hx < (CNT_W+1)'(H_ACT0 + H_ACTIVE)) &&
                 (vx >= (CNT_W+1)'(V_ACT0)) && (vx < (CNT_W+1)'(V_ACT0 + V_ACTIVE));
        x_n    = '0;
        y_n    = '0;
        if (active) begin
            x_n = h - CNT_W'(H_ACT0);
            y_n = v - CNT_W'(V_ACT0);
        end
    end

    // moved marks that the counters took a new position on the previous
    // clock (or were just reset), so each pulse fires exactly once.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            vga.HS          <= ~HS_POL;
            vga.VS          <= ~VS_POL;
            vga.vidSel      <= 1'b0;
            vga.hcount      <= '0;
            vga.vcount      <= '0;
            vga.x           <= '0;
            vga.y           <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            moved           <= 1'b1;
        end else begin
            vga.HS          <= hs_on ? HS_POL : ~HS_POL;
            vga.VS          <= vs_on ? VS_POL : ~VS_POL;
            vga.vidSel      <= active;
            vga.hcount      <= h;
            vga.vcount      <= v;
            vga.x           <= x_n;
            vga.y           <= y_n;
            vga.line_start  <= moved && (h == '0);
            vga.frame_start <= moved && (h == '0) && (v == '0);
            moved           <= tick;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BW   = H_ACTIVE / 8;
    localparam int CH_W = RGB_W / 3;

    logic [CNT_W-1:0] bar;
    logic [2:0]       code;

    // code is {R,G,B}; bars past the eighth clamp to the last (black) one.
    always_comb begin
        bar  = x_n / CNT_W'(BW);
        code = 3'b000;
        if (bar <= CNT_W'(7)) begin
            case (bar[2:0])
                3'd0:    code = 3'b111;
                3'd1:    code = 3'b110;
                3'd2:    code = 3'b011;
                3'd3:    code = 3'b010;
                3'd4:    code = 3'b101;
                3'd5:    code = 3'b100;
                3'd6:    code = 3'b001;
                default: code = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            vga.rgb <= '0;
        end else if (active) begin
            vga.rgb <= RGB_W'({{CH_W{code[2]}}, {CH_W{code[1]}}, {CH_W{code[0]}}});
        end else begin
            vga.rgb <= '0;
        end
    end
`else
    assign vga.rgb = RGB_W'(0);
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster: fixed vectors,
// hand-written period/enable/reset sequences and randomised en/reset_n.
module tb_vga_timing_gen;
    localparam int CLK_DIV  = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 2;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;
    localparam int CNT_W    = 6;
    localparam int RGB_W    = 12;
    localparam int HT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0      = H_SYNC + H_BP;
    localparam int VA0      = V_SYNC + V_BP;

    logic clk100 = 1'b0;
    logic reset_n;

    vga_timing_gen_if #(.CNT_W(CNT_W), .RGB_W(RGB_W)) bus ();

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W), .RGB_W(RGB_W)
    ) dut (
        .clk100 (clk100),
        .reset_n(reset_n),
        .vga    (bus)
    );

    always #5 clk100 = ~clk100;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             vid;
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] vc;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             ls;
        logic             fs;
        logic [RGB_W-1:0] rgb;
    } out_t;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit vid;
        int x;
        int y;
    } vec_t;

    int   checks = 0;
    int   passes = 0;
    int   tick_seen = 0;
    bit   model_ok = 0;
    int   n_ticks = 0;
    int   e_cnt = 0;
    bit   fresh = 0;
    out_t exp_out;

    // Reference colour for one pixel; bars are H_ACTIVE/8 wide, clamped at 7.
    function automatic logic [RGB_W-1:0] pattern_colour(input bit vid, input int x);
`ifdef VGA_TEST_PATTERN_EN
        int bar;
        if (!vid) return '0;
        bar = x / (H_ACTIVE / 8);
        if (bar > 7) bar = 7;
        case (bar)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
`else
        if (vid && x < 0) return '1;
        return '0;
`endif
    endfunction

    // Position is derived from the total pixel count since reset.
    function automatic out_t model_decode(input int n, input bit fr);
        out_t o;
        int   h;
        int   v;
        bit   vid;
        h     = n % HT;
        v     = (n / HT) % VT;
        vid   = (h >= HA0) && (h < HA0 + H_ACTIVE) && (v >= VA0) && (v < VA0 + V_ACTIVE);
        o.hs  = (h < H_SYNC) ? HS_POL : !HS_POL;
        o.vs  = (v < V_SYNC) ? VS_POL : !VS_POL;
        o.vid = vid;
        o.hc  = CNT_W'(h);
        o.vc  = CNT_W'(v);
        o.x   = vid ? CNT_W'(h - HA0) : '0;
        o.y   = vid ? CNT_W'(v - VA0) : '0;
        o.ls  = fr && (h == 0);
        o.fs  = fr && (h == 0) && (v == 0);
        o.rgb = pattern_colour(vid, h - HA0);
        return o;
    endfunction

    function automatic out_t reset_out();
        out_t o;
        o     = '0;
        o.hs  = !HS_POL;
        o.vs  = !VS_POL;
        return o;
    endfunction

    function automatic out_t sample_dut();
        out_t o;
        o.hs  = bus.HS;
        o.vs  = bus.VS;
        o.vid = bus.vidSel;
        o.hc  = bus.hcount;
        o.vc  = bus.vcount;
        o.x   = bus.x;
        o.y   = bus.y;
        o.ls  = bus.line_start;
        o.fs  = bus.frame_start;
        o.rgb = bus.rgb;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, check pix_tick, clock, advance model, check outputs.
    task automatic applyStimulus(input bit en_v, input bit rstn_v);
        bit tick;
        bus.en  = en_v;
        reset_n = rstn_v;
        #1;
        if (bus.pix_tick === 1'b1) tick_seen++;
        if (model_ok) begin
            tick = en_v && ((e_cnt % CLK_DIV) == CLK_DIV - 1);
            checkOutput("pix_tick", 64'(bus.pix_tick), 64'(tick));
        end
        @(posedge clk100);
        #1;
        if (!rstn_v) begin
            exp_out  = reset_out();
            n_ticks  = 0;
            e_cnt    = 0;
            fresh    = 1;
            model_ok = 1;
        end else if (model_ok) begin
            exp_out = model_decode(n_ticks, fresh);
            tick    = en_v && ((e_cnt % CLK_DIV) == CLK_DIV - 1);
            if (en_v) e_cnt++;
            if (tick) n_ticks++;
            fresh = tick;
        end
        if (model_ok) checkOutput("outputs", 64'(sample_dut()), 64'(exp_out));
    endtask

    task automatic measure_period(input bit frame, input bit drop_en, output int period);
        bit seen;
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            applyStimulus(1'b1, 1'b1);
            seen = frame ? bus.frame_start : bus.line_start;
        end
        if (!seen) begin
            period = -1;
            return;
        end
        period = 0;
        if (drop_en) begin
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b1, 1'b1);
                period++;
            end
            for (int k = 0; k < 37; k++) begin
                applyStimulus(1'b0, 1'b1);
                period++;
            end
        end
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            applyStimulus(1'b1, 1'b1);
            period++;
            seen = frame ? bus.frame_start : bus.line_start;
        end
        if (!seen) period = -1;
    endtask

    task automatic seek(input int h, input int v, output bit found);
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            applyStimulus(1'b1, 1'b1);
            found = (bus.hcount == CNT_W'(h)) && (bus.vcount == CNT_W'(v));
        end
    endtask

    initial begin
        vec_t vecs[10];
        bit   found;
        int   period;
        int   ticks_before;

        vecs[0] = '{0,  0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{2,  0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{3,  1, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[3] = '{5,  2, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{5,  3, 1'b1, 1'b0, 1'b1, 0, 0};
        vecs[5] = '{12, 6, 1'b1, 1'b0, 1'b1, 7, 3};
        vecs[6] = '{13, 6, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[7] = '{12, 7, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[8] = '{4,  3, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[9] = '{14, 8, 1'b1, 1'b0, 1'b0, 0, 0};

        bus.en  = 1'b0;
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            seek(vecs[i].h, vecs[i].v, found);
            checkOutput($sformatf("seek_%0d", i), 64'(found), 64'(1));
            if (found) begin
                checkOutput($sformatf("vector_%0d", i),
                            64'({bus.HS, bus.VS, bus.vidSel, bus.x, bus.y}),
                            64'({vecs[i].hs, vecs[i].vs, vecs[i].vid, CNT_W'(vecs[i].x), CNT_W'(vecs[i].y)}));
            end
        end

        measure_period(1'b0, 1'b0, period);
        checkOutput("line_period", 64'(period), 64'(HT * CLK_DIV));
        measure_period(1'b1, 1'b0, period);
        checkOutput("frame_period", 64'(period), 64'(HT * VT * CLK_DIV));

        ticks_before = tick_seen;
        measure_period(1'b0, 1'b1, period);
        checkOutput("line_period_en_drop", 64'(period), 64'(HT * CLK_DIV + 37));

        ticks_before = tick_seen;
        for (int k = 0; k < 37; k++) applyStimulus(1'b0, 1'b1);
        checkOutput("en_low_ticks", 64'(tick_seen - ticks_before), 64'(0));

        seek(9, 4, found);
        checkOutput("seek_reset_point", 64'(found), 64'(1));
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_reset", 64'({bus.HS, bus.VS, bus.vidSel, bus.line_start, bus.frame_start}),
                    64'(5'b10000));
        applyStimulus(1'b1, 1'b1);
        checkOutput("after_release", 64'({bus.hcount, bus.vcount, bus.HS, bus.VS, bus.line_start, bus.frame_start}),
                    64'({CNT_W'(0), CNT_W'(0), 4'b0111}));

        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 299) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
